// File: rtl/fp_accum_pkg.sv
//----------------------------------------------------------------------------
// fp_accum_pkg : number-format defines, shared constants and FSM encoding
// Rev 1.0      : initial release
//----------------------------------------------------------------------------
`default_nettype none

`ifndef FP_ACCUM_DEFS
`define FP_ACCUM_DEFS
`define EXP_W  8
`define M_W    7
`define BIT_W  (1 + `EXP_W + `M_W)
`define MULT_W (2 * (`M_W + 1))
`endif

package fp_accum_pkg;

    localparam int BIT_W = `BIT_W;
    localparam int EXP_W = `EXP_W;
    localparam int M_W   = `M_W;

    localparam int                EXP_BIAS = 2 ** (`EXP_W - 1) - 1;
    localparam logic [EXP_W-1:0]  EXP_MAX  = '1;

    // Significand: hidden bit + mantissa + 2 guard bits; sum adds a carry bit
    localparam int MX_W  = M_W + 3;
    localparam int SUM_W = M_W + 4;
    localparam int LZC_W = $clog2(SUM_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_EMIT  = 3'd4
    } state_t;

    function automatic logic [MX_W-1:0] sig_of(input logic [EXP_W-1:0] e,
                                               input logic [M_W-1:0]   m);
        return (e == '0) ? '0 : {1'b1, m, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_accum_lzc.sv
//----------------------------------------------------------------------------
// fp_lzc : combinational leading-zero counter over the unnormalised sum
// Rev 1.0: initial release
//----------------------------------------------------------------------------
`default_nettype none

module fp_lzc
    import fp_accum_pkg::*;
(
    input  logic [SUM_W-1:0] sum,
    output logic [LZC_W-1:0] lzc
);

    // Scanning upward lets the highest set bit win the last assignment
    always_comb begin
        lzc = LZC_W'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            if (sum[i]) begin
                lzc = LZC_W'(SUM_W - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_accum.sv
//----------------------------------------------------------------------------
// fp_accum : sequential FP accumulator, 4-cycle align/add/normalise per term
// Optional : FP_ACCUM_OVF_FLAG_EN adds the sticky out_ovf flag
// Rev 1.0  : initial release
//----------------------------------------------------------------------------
`default_nettype none

module fp_accum
    import fp_accum_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [`BIT_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [`BIT_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count
`ifdef FP_ACCUM_OVF_FLAG_EN
    ,
    output logic              out_ovf
`endif
);

    localparam logic signed [EXP_W:0] C_EXP_ONE  = (EXP_W + 1)'(1);
    localparam logic signed [EXP_W:0] C_EXP_ZERO = '0;
    localparam logic signed [EXP_W:0] C_EXP_SAT  = {1'b0, EXP_MAX};

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [BIT_W-1:0]   r_out_data;
    logic [CNT_W-1:0]   r_out_count;
    logic [BIT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [BIT_W-1:0]   r_a;
    logic [BIT_W-1:0]   r_b;
    logic               r_last;
    logic               r_x_sign;
    logic               r_sub;
    logic [EXP_W-1:0]   r_ex;
    logic [MX_W-1:0]    r_mx;
    logic [MX_W-1:0]    r_my;
    logic               r_sat;
    logic               r_sat_sign;
    logic [SUM_W-1:0]   r_sum;

    logic [EXP_W-1:0]   w_a_exp, w_b_exp, w_x_exp, w_y_exp, w_diff;
    logic [MX_W-1:0]    w_a_sig, w_b_sig, w_x_sig, w_y_sig, w_y_shift;
    logic               w_a_sat, w_b_sat, w_b_is_x;

    logic [LZC_W-1:0]        w_lzc;
    logic [SUM_W-1:0]        w_norm;
    logic signed [EXP_W:0]   w_ex_s, w_lzc_s, w_exp_res;
    logic [BIT_W-1:0]        w_res;
    logic                    w_res_sat;
    logic [CNT_W-1:0]        w_count_next;
    logic                    w_unused_guard;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

    // Operand ordering and alignment: X is the larger magnitude
    always_comb begin
        w_a_exp   = r_a[BIT_W-2:M_W];
        w_b_exp   = r_b[BIT_W-2:M_W];
        w_a_sig   = sig_of(w_a_exp, r_a[M_W-1:0]);
        w_b_sig   = sig_of(w_b_exp, r_b[M_W-1:0]);
        w_a_sat   = (w_a_exp == EXP_MAX);
        w_b_sat   = (w_b_exp == EXP_MAX);
        w_b_is_x  = {w_b_exp, w_b_sig} > {w_a_exp, w_a_sig};
        w_x_exp   = w_b_is_x ? w_b_exp : w_a_exp;
        w_y_exp   = w_b_is_x ? w_a_exp : w_b_exp;
        w_x_sig   = w_b_is_x ? w_b_sig : w_a_sig;
        w_y_sig   = w_b_is_x ? w_a_sig : w_b_sig;
        w_diff    = w_x_exp - w_y_exp;
        w_y_shift = (w_diff >= EXP_W'(M_W + 2)) ? '0 : (w_y_sig >> w_diff);
    end

    fp_lzc u_lzc (
        .sum (r_sum),
        .lzc (w_lzc)
    );

    // Normalise: hidden bit lands at the top of w_norm, so exponent moves by 1-lzc
    always_comb begin
        w_norm    = r_sum << w_lzc;
        w_ex_s    = {1'b0, r_ex};
        w_lzc_s   = {{(EXP_W + 1 - LZC_W){1'b0}}, w_lzc};
        w_exp_res = w_ex_s + C_EXP_ONE - w_lzc_s;
        w_res_sat = 1'b0;
        if (r_sat) begin
            w_res     = {r_sat_sign, EXP_MAX, {M_W{1'b0}}};
            w_res_sat = 1'b1;
        end else if (!w_norm[SUM_W-1] || (w_exp_res <= C_EXP_ZERO)) begin
            w_res = '0;
        end else if (w_exp_res >= C_EXP_SAT) begin
            w_res     = {r_x_sign, EXP_MAX, {M_W{1'b0}}};
            w_res_sat = 1'b1;
        end else begin
            w_res = {r_x_sign, w_exp_res[EXP_W-1:0], w_norm[SUM_W-2 -: M_W]};
        end
        w_count_next = (r_count == '1) ? r_count : r_count + 1'b1;
    end

    assign w_unused_guard = ^w_norm[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_last      <= 1'b0;
            r_x_sign    <= 1'b0;
            r_sub       <= 1'b0;
            r_ex        <= '0;
            r_mx        <= '0;
            r_my        <= '0;
            r_sat       <= 1'b0;
            r_sat_sign  <= 1'b0;
            r_sum       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= r_acc;
                        r_b        <= in_data;
                        r_last     <= in_last;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    r_x_sign   <= w_b_is_x ? r_b[BIT_W-1] : r_a[BIT_W-1];
                    r_sub      <= r_a[BIT_W-1] ^ r_b[BIT_W-1];
                    r_ex       <= w_x_exp;
                    r_mx       <= w_x_sig;
                    r_my       <= w_y_shift;
                    r_sat      <= w_a_sat | w_b_sat;
                    // Two saturated operands keep the accumulator's sign
                    r_sat_sign <= (w_a_sat && w_b_sat) ? r_a[BIT_W-1]
                                : (w_b_is_x ? r_b[BIT_W-1] : r_a[BIT_W-1]);
                    r_state    <= ST_ADD;
                end
                ST_ADD: begin
                    r_sum   <= r_sub ? ({1'b0, r_mx} - {1'b0, r_my})
                                     : ({1'b0, r_mx} + {1'b0, r_my});
                    r_state <= ST_NORM;
                end
                ST_NORM: begin
                    r_acc   <= w_res;
                    r_count <= w_count_next;
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_res;
                        r_out_count <= w_count_next;
                        r_state     <= ST_EMIT;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FP_ACCUM_OVF_FLAG_EN
    logic r_ovf;

    assign out_ovf = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_NORM) begin
            r_ovf <= r_ovf | w_res_sat;
        end else if ((r_state == ST_EMIT) && out_ready) begin
            r_ovf <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_accum.sv
//----------------------------------------------------------------------------
// tb_fp_accum : randomized self-checking bench for fp_accum (bfloat16)
// Rev 1.0     : initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_fp_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_count;
`ifdef FP_ACCUM_OVF_FLAG_EN
    logic        out_ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rand_ready = 1'b0;
    bit ready_req  = 1'b1;

    typedef struct {
        logic [15:0] d;
        int          c;
        bit          o;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_acc = '0;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;

    fp_accum #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
`ifdef FP_ACCUM_OVF_FLAG_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // out_ready only changes just after a rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_req;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Value-level reference: significands as integers with 2 guard bits
    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, sa, sb, ex, ey, sx, sy, s, p, e, mant;
        bit xs, ys;
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        sa = (ea == 0) ? 0 : (128 + int'(a[6:0])) * 4;
        sb = (eb == 0) ? 0 : (128 + int'(b[6:0])) * 4;
        if (ea == 255 && eb == 255) return {1'b1, a[15], 8'hFF, 7'h00};
        if (eb > ea || (eb == ea && sb > sa)) begin
            ex = eb; sx = sb; xs = b[15]; ey = ea; sy = sa; ys = a[15];
        end else begin
            ex = ea; sx = sa; xs = a[15]; ey = eb; sy = sb; ys = b[15];
        end
        if (ea == 255 || eb == 255) return {1'b1, xs, 8'hFF, 7'h00};
        sy = (ex - ey >= 9) ? 0 : (sy >> (ex - ey));
        s  = (xs == ys) ? sx + sy : sx - sy;
        if (s == 0) return 17'h0;
        p = 0;
        for (int i = 0; i < 12; i++) if (s[i]) p = i;
        e = ex + p - 9;
        if (e <= 0) return 17'h0;
        if (e >= 255) return {1'b1, xs, 8'hFF, 7'h00};
        mant = (p >= 7) ? (s >> (p - 7)) : (s << (7 - p));
        return {1'b0, xs, e[7:0], mant[6:0]};
    endfunction

    function automatic logic [15:0] rand_term();
        int          sel;
        logic [7:0]  e;
        logic        s;
        logic [6:0]  m;
        sel = $urandom_range(0, 19);
        s   = 1'($urandom);
        m   = 7'($urandom);
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) return {s, 8'hFF, 7'h00};
        else if (sel <= 3) e = 8'($urandom_range(248, 254));
        else if (sel <= 5) e = 8'($urandom_range(1, 12));
        else               e = 8'($urandom_range(118, 136));
        return {s, e, m};
    endfunction

    task automatic model_reset();
        m_acc = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic send(input logic [15:0] d, input bit last, output int acc_cyc);
        logic [16:0] r;
        int          g;
        g        = 0;
        acc_cyc  = -100;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            acc_cyc = cyc;
            r       = ref_add(m_acc, d);
            m_acc   = r[15:0];
            m_ovf   = m_ovf | r[16];
            m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (last) begin
                exp_q.push_back('{d: m_acc, c: m_cnt, o: m_ovf});
                m_acc = '0;
                m_cnt = 0;
                m_ovf = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input int acc_cyc, output logic [15:0] d, output int n);
        int g;
        g = 0;
        while (!out_valid && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("out_timeout", 32'(out_valid), 32'd1);
        check("latency", 32'(cyc - acc_cyc), 32'd4);
        d = out_data;
        n = int'(out_count);
    endtask

    // Scoreboard on every output handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sum", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum_data", 32'(out_data), 32'(e.d));
                check("sum_count", 32'(out_count), 32'(e.c));
`ifdef FP_ACCUM_OVF_FLAG_EN
                check("sum_ovf", 32'(out_ovf), 32'(e.o));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int          n, c, g;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        send(16'h3F80, 1'b0, c);
        send(16'h4000, 1'b1, c);
        wait_out(c, d, n);
        check("one_plus_two", 32'(d), 32'h4040);
        check("one_plus_two_cnt", 32'(n), 32'd2);

        send(16'h3F80, 1'b0, c);
        send(16'hBF80, 1'b1, c);
        wait_out(c, d, n);
        check("cancel_zero", 32'(d), 32'h0000);
        check("cancel_cnt", 32'(n), 32'd2);

        send(16'h7F00, 1'b0, c);
        send(16'h7F00, 1'b1, c);
        wait_out(c, d, n);
        check("overflow_sat", 32'(d), 32'h7F80);
`ifdef FP_ACCUM_OVF_FLAG_EN
        check("overflow_flag", 32'(out_ovf), 32'd1);
`endif

        send(16'h3F80, 1'b0, c);
        send(16'h3A80, 1'b1, c);
        wait_out(c, d, n);
        check("far_operand", 32'(d), 32'h3F80);
        check("far_operand_cnt", 32'(n), 32'd2);

        // Backpressure in EMIT: output frozen, new input refused
        ready_req = 1'b0;
        repeat (2) @(negedge clk);
        send(16'h3F80, 1'b0, c);
        send(16'h4000, 1'b1, c);
        wait_out(c, d, n);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h3F80;
            in_last  = 1'b1;
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'h4040);
            check("stall_count", 32'(out_count), 32'd2);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        ready_req = 1'b1;
        repeat (2) @(negedge clk);
        check("stall_release", 32'(out_valid), 32'd0);
        send(16'hC000, 1'b1, c);
        wait_out(c, d, n);
        check("fresh_sum", 32'(d), 32'hC000);
        check("fresh_sum_cnt", 32'(n), 32'd1);

        // Reset while the second term is in ADD
        send(16'h3F80, 1'b0, c);
        send(16'h4000, 1'b0, c);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        send(16'h4040, 1'b1, c);
        wait_out(c, d, n);
        check("after_rst", 32'(d), 32'h4040);
        check("after_rst_cnt", 32'(n), 32'd1);

        // Counter saturation at 2^CNT_W-1
        for (int i = 0; i < 259; i++) send(rand_term(), (i == 258), c);
        wait_out(c, d, n);
        check("count_sat", 32'(n), 32'd255);

        // Random traffic with random output backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(rand_term(), (i == 199) || ($urandom_range(0, 3) == 0), c);
        end
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
